// File: rtl/enable_pacer.sv
// Request pacer for the saturating event counter: buffers valid/ready requests and
// issues single-cycle, spaced enable pulses until the downstream count saturates.
module enable_pacer #(
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned SAT_VAL  = 5,
    parameter int unsigned MAX_PEND = 7,
    parameter int unsigned HOLDOFF  = 2,
    localparam int unsigned PEND_W  = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CNT_W-1:0]  count_in,
    output logic              enable,
    output logic [PEND_W-1:0] pending,
    output logic              saturated,
    output logic              dropped
);

    localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                hold_last;
    logic                leave_pulse;
    logic                accept;

    // Ready looks only at registers, so no input reaches an output combinationally.
    assign req_ready = (pending != PEND_W'(MAX_PEND)) || saturated;
    assign accept    = req_valid && req_ready;
    assign hold_last = (32'(hold_cnt) + 32'd1) >= HOLDOFF;

    always_comb begin
        state_next  = state;
        leave_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (!saturated && (pending != '0)) state_next = PULSE;
            end
            PULSE: begin
                leave_pulse = 1'b1;
                if (HOLDOFF > 0)                                       state_next = HOLD;
                else if ((pending != PEND_W'(1)) && !saturated)        state_next = PULSE;
                else                                                   state_next = IDLE;
            end
            HOLD: begin
                if (hold_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            enable    <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_next;
            enable    <= (state_next == PULSE);
            hold_cnt  <= (state == HOLD && !hold_last) ? hold_cnt + HOLD_W'(1) : '0;
        end
    end

    // Saturation flushes the buffer and turns any accepted request into a drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            saturated <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            saturated <= (count_in >= CNT_W'(SAT_VAL));
            dropped   <= accept && saturated;
            if (saturated) begin
                pending <= '0;
            end else if (accept && !leave_pulse) begin
                pending <= pending + PEND_W'(1);
            end else if (!accept && leave_pulse) begin
                pending <= pending - PEND_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_enable_pacer.sv
// Directed bench for enable_pacer with default parameters; cycle n means just after edge n.
module tb_enable_pacer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] count_in;
    logic       enable;
    logic [2:0] pending;
    logic       saturated;
    logic       dropped;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    enable_pacer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .count_in  (count_in),
        .enable    (enable),
        .pending   (pending),
        .saturated (saturated),
        .dropped   (dropped)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; count_in = 3'd0;
        tick(); tick();
        total++;
        if ({enable, pending, saturated, dropped} !== 6'b0) begin
            bad++; $display("FAIL reset_outputs got %b want %b", {enable, pending, saturated, dropped}, 6'b0);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got %b want 1", req_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        total++;
        if (pending !== 3'd1 || enable !== 1'b0) begin
            bad++; $display("FAIL single_c1 got pend=%0d en=%b want pend=1 en=0", pending, enable);
        end
        tick();
        total++;
        if (enable !== 1'b1) begin
            bad++; $display("FAIL single_c2_enable got %b want 1", enable);
        end
        tick();
        total++;
        if (enable !== 1'b0 || pending !== 3'd0) begin
            bad++; $display("FAIL single_c3 got en=%b pend=%0d want en=0 pend=0", enable, pending);
        end
    endtask

    task automatic test_spacing();
        logic exp_en;
        for (int c = 1; c <= 12; c++) begin
            req_valid = (c <= 3);
            tick();
            exp_en = (c == 2 || c == 6 || c == 10);
            total++;
            if (enable !== exp_en) begin
                bad++; $display("FAIL spacing_c%0d got en=%b want %b", c, enable, exp_en);
            end
        end
        req_valid = 1'b0;
        total++;
        if (pending !== 3'd0) begin
            bad++; $display("FAIL spacing_drain got pend=%0d want 0", pending);
        end
    endtask

    task automatic test_back_to_back();
        int exp_p [12] = '{1, 2, 2, 3, 4, 5, 5, 6, 7, 7, 6, 7};
        int exp_e [12] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
        int accepts = 0;
        int enables = 0;
        for (int c = 1; c <= 12; c++) begin
            req_valid = 1'b1;
            if (req_ready) accepts++;
            tick();
            if (enable) enables++;
            total++;
            if (pending !== 3'(exp_p[c-1]) || enable !== 1'(exp_e[c-1])) begin
                bad++; $display("FAIL b2b_c%0d got pend=%0d en=%b want pend=%0d en=%0d",
                                c, pending, enable, exp_p[c-1], exp_e[c-1]);
            end
            total++;
            if (req_ready !== (exp_p[c-1] != 7)) begin
                bad++; $display("FAIL b2b_ready_c%0d got %b want %b", c, req_ready, exp_p[c-1] != 7);
            end
        end
        req_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (enable) enables++;
        end
        total++;
        if (accepts != 10) begin
            bad++; $display("FAIL b2b_accepts got %0d want 10", accepts);
        end
        total++;
        if (enables != accepts || pending !== 3'd0) begin
            bad++; $display("FAIL b2b_enables got en=%0d pend=%0d want en=%0d pend=0", enables, pending, accepts);
        end
    endtask

    task automatic test_reset_in_hold();
        int extra = 0;
        for (int c = 1; c <= 4; c++) begin
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        total++;
        if (pending !== 3'd3 || enable !== 1'b0) begin
            bad++; $display("FAIL hold_setup got pend=%0d en=%b want pend=3 en=0", pending, enable);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({enable, pending, saturated, dropped} !== 6'b0) begin
            bad++; $display("FAIL hold_reset got %b want %b", {enable, pending, saturated, dropped}, 6'b0);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (enable) extra++;
        end
        total++;
        if (extra != 0 || pending !== 3'd0) begin
            bad++; $display("FAIL hold_after got en=%0d pend=%0d want en=0 pend=0", extra, pending);
        end
    endtask

    task automatic test_saturate();
        int extra = 0;
        for (int c = 1; c <= 5; c++) begin
            req_valid = 1'b1;
            if (c == 5) count_in = 3'd5;
            tick();
        end
        req_valid = 1'b0;
        total++;
        if (saturated !== 1'b1 || pending !== 3'd4 || enable !== 1'b0) begin
            bad++; $display("FAIL sat_c5 got sat=%b pend=%0d en=%b want sat=1 pend=4 en=0",
                            saturated, pending, enable);
        end
        tick();
        total++;
        if (pending !== 3'd0 || enable !== 1'b0) begin
            bad++; $display("FAIL sat_flush got pend=%0d en=%b want pend=0 en=0", pending, enable);
        end
        req_valid = 1'b1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL sat_ready got %b want 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        total++;
        if (dropped !== 1'b1 || pending !== 3'd0) begin
            bad++; $display("FAIL sat_drop got drop=%b pend=%0d want drop=1 pend=0", dropped, pending);
        end
        tick();
        total++;
        if (dropped !== 1'b0) begin
            bad++; $display("FAIL sat_drop_end got %b want 0", dropped);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            if (enable) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++; $display("FAIL sat_no_enable got %0d want 0", extra);
        end
    endtask

    task automatic test_unsaturate();
        count_in = 3'd0;
        tick();
        total++;
        if (saturated !== 1'b0) begin
            bad++; $display("FAIL unsat_clear got %b want 0", saturated);
        end
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        total++;
        if (pending !== 3'd1 || enable !== 1'b0 || dropped !== 1'b0) begin
            bad++; $display("FAIL unsat_accept got pend=%0d en=%b drop=%b want 1 0 0", pending, enable, dropped);
        end
        tick();
        total++;
        if (enable !== 1'b1) begin
            bad++; $display("FAIL unsat_enable got %b want 1", enable);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        idle(6);
        test_spacing();
        idle(6);
        test_back_to_back();
        idle(6);
        test_reset_in_hold();
        idle(6);
        test_saturate();
        test_unsaturate();
        idle(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
